// File: rtl/mem_pipe.sv
// Memory stage of the integer/FP pipeline: issues one data-memory access per
// load/store, stalls upstream until it completes, and drives the M/W register.
module mem_pipe (
  input  logic        clk,
  input  logic        rstn,
  // X/M pipeline register
  input  logic        mem_to_reg_xm,
  input  logic        reg_write_xm,
  input  logic        mem_read_xm,
  input  logic        mem_write_xm,
  input  logic        fp_operation_xm,
  input  logic [31:0] alu_out_xm,
  input  logic [31:0] alu_out_fp_xm,
  input  logic [4:0]  rd_addr_xm,
  input  logic [31:0] mem_data_xm,
  input  logic [31:0] mem_data_fp_xm,
  // data memory
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // pipeline control / status
  output logic        stall_o,
  output logic        err_o,
  // M/W pipeline register
  output logic        mem_to_reg_mw,
  output logic        reg_write_mw,
  output logic        fp_operation_mw,
  output logic [4:0]  rd_addr_mw,
  output logic [31:0] alu_out_mw,
  output logic [31:0] alu_out_fp_mw,
  output logic [31:0] mem_data_to_reg_mw,
  output logic [31:0] mem_data_to_reg_fp
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  state_t      r_state, w_state_nxt;
  dmem_req_t   r_req;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_cap_data;
  logic        r_err;

  logic        w_access;
  logic        w_stall;
  logic        w_cnt_max;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  assign w_access  = mem_read_xm | mem_write_xm;
  assign w_cnt_max = (r_wait_cnt == 4'hF);
  assign w_addr    = fp_operation_xm ? alu_out_fp_xm  : alu_out_xm;
  assign w_wdata   = fp_operation_xm ? mem_data_fp_xm : mem_data_xm;

  // Next state and the combinational stall.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_stall     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (dmem_ack || w_cnt_max) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset forces IDLE, but a load/store still sitting in X/M must not
  // raise stall while reset is held.
  assign stall_o = w_stall & rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Memory request, wait counter, read capture and timeout flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req      <= '0;
      r_wait_cnt <= '0;
      r_cap_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_access) begin
            r_req.req   <= 1'b1;
            r_req.we    <= ~mem_read_xm;
            r_req.addr  <= {w_addr[31:2], 2'b00};
            r_req.wdata <= w_wdata;
          end
        end
        BUSY: begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
          // A completion arriving on the last wait cycle beats the timeout.
          if (dmem_ack) begin
            r_cap_data <= dmem_rdata;
            r_req.req  <= 1'b0;
          end else if (w_cnt_max) begin
            r_cap_data <= '0;
            r_err      <= 1'b1;
            r_req.req  <= 1'b0;
          end
        end
        default: r_wait_cnt <= '0;
      endcase
    end
  end

  assign dmem_req   = r_req.req;
  assign dmem_we    = r_req.we;
  assign dmem_addr  = r_req.addr;
  assign dmem_wdata = r_req.wdata;
  assign err_o      = r_err;

  // M/W register: bubble while stalled, otherwise follow X/M.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_to_reg_mw   <= 1'b0;
      reg_write_mw    <= 1'b0;
      fp_operation_mw <= 1'b0;
      rd_addr_mw      <= '0;
      alu_out_mw      <= '0;
      alu_out_fp_mw   <= '0;
    end else if (w_stall) begin
      mem_to_reg_mw <= 1'b0;
      reg_write_mw  <= 1'b0;
    end else begin
      mem_to_reg_mw   <= mem_to_reg_xm;
      reg_write_mw    <= reg_write_xm;
      fp_operation_mw <= fp_operation_xm;
      rd_addr_mw      <= rd_addr_xm;
      alu_out_mw      <= alu_out_xm;
      alu_out_fp_mw   <= alu_out_fp_xm;
    end
  end

  // Load data is committed only as the access retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_data_to_reg_mw <= '0;
      mem_data_to_reg_fp <= '0;
    end else if (r_state == DONE && mem_read_xm) begin
      if (fp_operation_xm) mem_data_to_reg_fp <= r_cap_data;
      else                 mem_data_to_reg_mw <= r_cap_data;
    end
  end

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: ALU pass-through, int/FP loads and stores,
// timeout, ack-vs-timeout priority and reset during an outstanding access.
module tb_mem_pipe;

  logic        clk, rstn;
  logic        mem_to_reg_xm, reg_write_xm, mem_read_xm, mem_write_xm, fp_operation_xm;
  logic [31:0] alu_out_xm, alu_out_fp_xm, mem_data_xm, mem_data_fp_xm;
  logic [4:0]  rd_addr_xm;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_o, err_o;
  logic        mem_to_reg_mw, reg_write_mw, fp_operation_mw;
  logic [4:0]  rd_addr_mw;
  logic [31:0] alu_out_mw, alu_out_fp_mw, mem_data_to_reg_mw, mem_data_to_reg_fp;

  int n_cmp = 0;
  int n_mis = 0;

  mem_pipe dut (
    .clk(clk), .rstn(rstn),
    .mem_to_reg_xm(mem_to_reg_xm), .reg_write_xm(reg_write_xm),
    .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm),
    .fp_operation_xm(fp_operation_xm),
    .alu_out_xm(alu_out_xm), .alu_out_fp_xm(alu_out_fp_xm),
    .rd_addr_xm(rd_addr_xm),
    .mem_data_xm(mem_data_xm), .mem_data_fp_xm(mem_data_fp_xm),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .err_o(err_o),
    .mem_to_reg_mw(mem_to_reg_mw), .reg_write_mw(reg_write_mw),
    .fp_operation_mw(fp_operation_mw), .rd_addr_mw(rd_addr_mw),
    .alu_out_mw(alu_out_mw), .alu_out_fp_mw(alu_out_fp_mw),
    .mem_data_to_reg_mw(mem_data_to_reg_mw), .mem_data_to_reg_fp(mem_data_to_reg_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_to_reg_xm = 0; reg_write_xm = 0; mem_read_xm = 0; mem_write_xm = 0;
    fp_operation_xm = 0; alu_out_xm = 0; alu_out_fp_xm = 0; rd_addr_xm = 0;
    mem_data_xm = 0; mem_data_fp_xm = 0;
  endtask

  task automatic load(input logic fp, input logic [31:0] addr, input logic [4:0] rd);
    nop();
    mem_read_xm = 1; mem_to_reg_xm = 1; reg_write_xm = 1;
    fp_operation_xm = fp; rd_addr_xm = rd;
    if (fp) alu_out_fp_xm = addr; else alu_out_xm = addr;
    #1;
  endtask

  initial begin
    rstn = 0; dmem_ack = 0; dmem_rdata = 0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_reg_write_mw", reg_write_mw, 0);
    chk("rst_alu_out_mw", alu_out_mw, 0);
    chk("rst_mdr_mw", mem_data_to_reg_mw, 0);
    rstn = 1;

    // ALU op passes through with one cycle latency
    alu_out_xm = 32'h10; rd_addr_xm = 5; reg_write_xm = 1;
    #1 chk("alu_stall", stall_o, 0);
    tick();
    chk("alu_out_mw", alu_out_mw, 32'h10);
    chk("alu_rd_mw", rd_addr_mw, 5);
    chk("alu_rw_mw", reg_write_mw, 1);
    chk("alu_stall2", stall_o, 0);

    // lw, ack on the second BUSY cycle
    load(0, 32'h1003, 7);
    chk("lw_stall_c0", stall_o, 1);
    tick();
    chk("lw_req", dmem_req, 1);
    chk("lw_we", dmem_we, 0);
    chk("lw_addr", dmem_addr, 32'h1000);
    chk("lw_stall_c1", stall_o, 1);
    chk("lw_bubble_rw", reg_write_mw, 0);
    chk("lw_hold_alu", alu_out_mw, 32'h10);
    tick();
    chk("lw_stall_c2", stall_o, 1);
    chk("lw_req_c2", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    #1;
    chk("lw_done_stall", stall_o, 0);
    chk("lw_done_req", dmem_req, 0);
    chk("lw_done_rw", reg_write_mw, 0);
    chk("lw_done_mdr", mem_data_to_reg_mw, 0);
    tick();
    nop();
    #1;
    chk("lw_mdr", mem_data_to_reg_mw, 32'hDEADBEEF);
    chk("lw_rw_mw", reg_write_mw, 1);
    chk("lw_m2r_mw", mem_to_reg_mw, 1);
    chk("lw_rd_mw", rd_addr_mw, 7);
    chk("lw_alu_mw", alu_out_mw, 32'h1003);
    chk("lw_idle_stall", stall_o, 0);
    tick();
    chk("lw_rw_once", reg_write_mw, 0);
    chk("lw_mdr_hold", mem_data_to_reg_mw, 32'hDEADBEEF);

    // swc1, ack on the first BUSY cycle
    nop();
    mem_write_xm = 1; fp_operation_xm = 1;
    alu_out_fp_xm = 32'h20; mem_data_fp_xm = 32'h3F800000;
    alu_out_xm = 32'hABCD; mem_data_xm = 32'h11111111;
    #1 chk("sw_stall_c0", stall_o, 1);
    tick();
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_addr", dmem_addr, 32'h20);
    chk("sw_wdata", dmem_wdata, 32'h3F800000);
    chk("sw_stall_c1", stall_o, 1);
    dmem_ack = 1; dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 0;
    #1;
    chk("sw_done_stall", stall_o, 0);
    chk("sw_done_req", dmem_req, 0);
    tick();
    nop();
    #1;
    chk("sw_fp_mdr_hold", mem_data_to_reg_fp, 0);
    chk("sw_int_mdr_hold", mem_data_to_reg_mw, 32'hDEADBEEF);
    chk("sw_fp_mw", fp_operation_mw, 1);
    chk("sw_alu_fp_mw", alu_out_fp_mw, 32'h20);

    // lwc1 with both read and write set: read wins
    load(1, 32'h47, 2);
    mem_write_xm = 1;
    tick();
    chk("lwc1_we", dmem_we, 0);
    chk("lwc1_addr", dmem_addr, 32'h44);
    dmem_ack = 1; dmem_rdata = 32'h40490FDB;
    tick();
    dmem_ack = 0;
    tick();
    nop();
    #1;
    chk("lwc1_mdr_fp", mem_data_to_reg_fp, 32'h40490FDB);
    chk("lwc1_mdr_int", mem_data_to_reg_mw, 32'hDEADBEEF);

    // stray ack in IDLE is ignored
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    tick();
    dmem_ack = 0;
    tick();
    chk("stray_req", dmem_req, 0);
    chk("stray_mdr", mem_data_to_reg_mw, 32'hDEADBEEF);
    chk("stray_stall", stall_o, 0);

    // lw with no ack: 16 BUSY cycles then timeout
    load(0, 32'h200, 3);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("to_req_%0d", k), dmem_req, 1);
      chk($sformatf("to_stall_%0d", k), stall_o, 1);
    end
    chk("to_err_pre", err_o, 0);
    tick();
    chk("to_done_req", dmem_req, 0);
    chk("to_err", err_o, 1);
    chk("to_done_stall", stall_o, 0);
    tick();
    nop();
    alu_out_xm = 32'h99; reg_write_xm = 1;
    #1;
    chk("to_mdr_zero", mem_data_to_reg_mw, 0);
    chk("to_idle_stall", stall_o, 0);
    tick();
    chk("to_idle_alu", alu_out_mw, 32'h99);

    // ack on the last wait cycle beats the timeout
    load(0, 32'h300, 4);
    for (int k = 0; k < 16; k++) tick();
    chk("late_req", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 0;
    tick();
    nop();
    #1;
    chk("late_mdr", mem_data_to_reg_mw, 32'h12345678);
    chk("late_err_sticky", err_o, 1);

    // reset while BUSY
    load(0, 32'h400, 6);
    tick();
    chk("rb_req", dmem_req, 1);
    #2 rstn = 0;
    #1;
    chk("rb_req_rst", dmem_req, 0);
    chk("rb_stall_rst", stall_o, 0);
    chk("rb_err_rst", err_o, 0);
    chk("rb_mdr_rst", mem_data_to_reg_mw, 0);
    nop();
    tick();
    rstn = 1;
    dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
    tick();
    dmem_ack = 0;
    tick();
    chk("rb_post_req", dmem_req, 0);
    chk("rb_post_stall", stall_o, 0);
    chk("rb_post_mdr", mem_data_to_reg_mw, 0);
    chk("rb_post_err", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 mem_to_reg_xm  in  1  X/M select load data for write-back.
REQ-004 reg_write_xm  in  1  X/M register write enable.
REQ-005 mem_read_xm  in  1  X/M load request.
REQ-006 mem_write_xm  in  1  X/M store request.
REQ-007 fp_operation_xm  in  1  X/M FP op (lwc1/swc1/add.s/mul.s).
REQ-008 alu_out_xm  in  32  X/M integer ALU result / integer load-store address.
REQ-009 alu_out_fp_xm  in  32  X/M FP result / FP load-store address.
REQ-010 rd_addr_xm  in  5  X/M destination register.
REQ-011 mem_data_xm  in  32  X/M integer store data.
REQ-012 mem_data_fp_xm  in  32  X/M FP store data.
REQ-013 dmem_req  out  1  data-memory request, registered.
REQ-014 dmem_we  out  1  1 store, 0 load; valid with dmem_req.
REQ-015 dmem_addr  out  32  word address, bits [1:0] forced 0.
REQ-016 dmem_wdata  out  32  store data.
REQ-017 dmem_ack  in  1  memory completion strobe, one cycle.
REQ-018 dmem_rdata  in  32  load data, valid with dmem_ack.
REQ-019 stall_o  out  1  hold IF/ID/EX and X/M this cycle.
REQ-020 err_o  out  1  sticky memory-timeout flag.
REQ-021 mem_to_reg_mw, reg_write_mw, fp_operation_mw  out  1 each  M/W control.
REQ-022 rd_addr_mw  out  5  M/W destination register.
REQ-023 alu_out_mw  out  32  M/W integer result (forwarding source).
REQ-024 alu_out_fp_mw  out  32  M/W FP result (forwarding source).
REQ-025 mem_data_to_reg_mw  out  32  last integer load data.
REQ-026 mem_data_to_reg_fp  out  32  last FP load data (forwarding source).

Function
REQ-027 FSM states IDLE, BUSY, DONE; access = mem_read_xm | mem_write_xm.
REQ-028 IDLE & access: stall_o=1 combinationally; next BUSY; register dmem_req=1, dmem_we=~mem_read_xm (read wins if both set), dmem_addr=(fp_operation_xm ? alu_out_fp_xm : alu_out_xm) with [1:0]=0, dmem_wdata=(fp_operation_xm ? mem_data_fp_xm : mem_data_xm).
REQ-029 BUSY: stall_o=1; dmem_req/we/addr/wdata held stable; 4-bit wait counter increments each cycle from 0.
REQ-030 BUSY & dmem_ack: capture dmem_rdata, dmem_req<=0, next DONE.
REQ-031 BUSY & no ack & counter==15: captured data=0, err_o<=1, dmem_req<=0, next DONE; ack in that same cycle wins, err_o unchanged.
REQ-032 DONE: stall_o=0; M/W loads from X/M; load with fp_operation_xm=1 writes captured data to mem_data_to_reg_fp, else mem_data_to_reg_mw; next IDLE.
REQ-033 IDLE & no access: stall_o=0; M/W loads from X/M every cycle (latency 1); mem_data_to_reg_* hold.
REQ-034 Any cycle with stall_o=1: M/W gets bubble (reg_write_mw=0, mem_to_reg_mw=0), other M/W fields hold.
REQ-035 dmem_ack outside BUSY ignored; err_o cleared only by reset.
REQ-036 Minimum load/store occupancy 3 cycles (IDLE, BUSY, DONE).

Reset
REQ-037 rstn low, asynchronously at any time including BUSY: state IDLE, counter 0, every output 0, outstanding access abandoned, late dmem_ack ignored.

Verification
REQ-038 ALU op alu_out_xm=0x10, rd=5, reg_write=1 -> next edge alu_out_mw=0x10, rd_addr_mw=5, reg_write_mw=1, stall_o=0.
REQ-039 lw alu_out_xm=0x1003, ack 2 cycles later with rdata=0xDEADBEEF -> dmem_addr=0x1000, stall_o high 3 cycles, mem_data_to_reg_mw=0xDEADBEEF, reg_write_mw=1 once.
REQ-040 swc1 alu_out_fp_xm=0x20, mem_data_fp_xm=0x3F800000, ack first BUSY cycle -> dmem_we=1, dmem_wdata=0x3F800000, stall_o 2 cycles.
REQ-041 lw with no ack -> dmem_req high 16 BUSY cycles, then err_o=1, mem_data_to_reg_mw=0, FSM IDLE.
REQ-042 rstn pulsed low in BUSY -> dmem_req=0, stall_o=0 immediately; ack after release leaves outputs at 0.
